store_unit: RTL and testbench

- Parametrised successor to the CPU's combinational byte-lane store formatter.
- Buffers store requests from the MEM stage in a small FIFO, formats them into byte-lane masks and shifted data, and drains them to the data memory.
- The memory side uses a valid/ready handshake with active-low byte write enables.
- Adds XLEN 32/64 support (SD), misaligned-store splitting into two beats, error reporting and an idle indication for fences.

---
 rtl/store_pkg.sv | 44 ++++
 rtl/store_fifo.sv | 62 ++++++
 rtl/store_unit.sv | 138 +++++++++++++
 tb/tb_store_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types and lane helpers for the store unit and its FIFO.
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1
  } state_e;

  // Position and log2 size of a store inside its word.
  typedef struct packed {
    logic [2:0] off;
    logic [1:0] lsize;
  } store_meta_t;

  // Byte span over two adjacent words: low NB bits are beat0, next NB bits are beat1.
  function automatic logic [15:0] span_mask(input logic [2:0] off, input logic [1:0] lsize);
    logic [15:0] ones;
    ones = (16'd1 << (5'd1 << lsize)) - 16'd1;
    return ones << off;
  endfunction

  // True when the store runs past the end of an NB-byte word.
  function automatic logic needs_split(input logic [2:0] off, input logic [1:0] lsize,
                                       input int unsigned nb);
    return (32'(off) + (32'd1 << lsize)) > nb;
  endfunction

  // Widen a per-byte mask into a per-bit mask.
  function automatic logic [63:0] lane_expand(input logic [7:0] m);
    logic [63:0] e;
    e = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      e[8*i +: 8] = {8{m[i]}};
    end
    return e;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Synchronous FIFO holding pending stores; dout always shows the head entry.
module store_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next pointer and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/store_unit.sv
// Buffered store formatter: queues MEM-stage stores and drains them as byte-lane beats.
module store_unit
  import store_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned AW             = 32,
  parameter int unsigned DEPTH          = 4,
  parameter bit          MISALIGN_SPLIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_funct3,
  input  logic [AW-1:0]       req_addr,
  input  logic [XLEN-1:0]     req_data,
  output logic                err,
  output logic                dm_valid,
  input  logic                dm_ready,
  output logic [AW-1:0]       dm_addr,
  output logic [XLEN/8-1:0]   dm_web,
  output logic [XLEN-1:0]     dm_wdata,
  output logic                idle
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned CW   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [AW-1:0]   addr;
    store_meta_t     meta;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t            new_entry, head;
  logic              push, pop, full, empty;
  logic [CW-1:0]     count;
  logic              accept, illegal, req_split, split, hi;
  logic [NB-1:0]     beat_mask;
  logic [2*XLEN-1:0] wide_data;
  logic [XLEN-1:0]   beat_data;
  state_e            state_q, state_d;
  logic              err_q, err_d;

  assign req_ready = !full;
  assign err       = err_q;
  assign idle      = (count == '0) && (state_q == IDLE);

  // Classify the incoming request and pack a word-aligned queue entry.
  always_comb begin
    new_entry            = '0;
    new_entry.addr       = {req_addr[AW-1:OFFW], {OFFW{1'b0}}};
    new_entry.meta.off   = 3'(req_addr[OFFW-1:0]);
    new_entry.meta.lsize = req_funct3[1:0];
    new_entry.data       = req_data;
    req_split = needs_split(new_entry.meta.off, new_entry.meta.lsize, NB);
    illegal   = req_funct3[2] || ((XLEN == 32) && (req_funct3 == F3_SD)) ||
                (!MISALIGN_SPLIT && req_split);
    accept    = req_valid && req_ready;
    push      = accept && !illegal;
    err_d     = accept && illegal;
  end

  store_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (new_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Format the head entry; the data is shifted into a double-width window so BEAT1
  // simply takes the upper word of the same span.
  always_comb begin
    hi        = (state_q == BEAT1);
    split     = needs_split(head.meta.off, head.meta.lsize, NB);
    wide_data = {{XLEN{1'b0}}, head.data} << {head.meta.off, 3'b000};
    beat_mask = NB'(span_mask(head.meta.off, head.meta.lsize) >> (hi ? NB : 0));
    beat_data = XLEN'(wide_data >> (hi ? XLEN : 0));
    dm_valid  = (state_q != IDLE);
    dm_addr   = '0;
    dm_web    = '1;
    dm_wdata  = '0;
    if (dm_valid) begin
      dm_addr  = hi ? (head.addr + AW'(NB)) : head.addr;
      dm_web   = ~beat_mask;
      dm_wdata = beat_data & XLEN'(lane_expand(8'(beat_mask)));
    end
  end

  // Drain sequencing: one or two beats per entry, popping after the last beat.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = BEAT0;
      end
      BEAT0: begin
        if (dm_ready) begin
          if (split) begin
            state_d = BEAT1;
          end else begin
            pop     = 1'b1;
            state_d = (count > CW'(1)) ? BEAT0 : IDLE;
          end
        end
      end
      BEAT1: begin
        if (dm_ready) begin
          pop     = 1'b1;
          state_d = (count > CW'(1)) ? BEAT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and error-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Bench: three configurations share one stimulus stream; a byte-level model predicts beats.
module tb_store_unit;
  import store_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned QN    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic        dm_ready = 1'b0;

  logic rr0, er0, dv0, idle0; logic [31:0] da0; logic [3:0] web0; logic [31:0] wd0;
  logic rr1, er1, dv1, idle1; logic [31:0] da1; logic [3:0] web1; logic [31:0] wd1;
  logic rr2, er2, dv2, idle2; logic [31:0] da2; logic [7:0] web2; logic [63:0] wd2;

  always #5 clk = ~clk;

  store_unit #(.XLEN(32), .AW(32), .DEPTH(DEPTH), .MISALIGN_SPLIT(1'b1)) u_split32 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr0), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_data(req_data[31:0]), .err(er0), .dm_valid(dv0),
    .dm_ready(dm_ready), .dm_addr(da0), .dm_web(web0), .dm_wdata(wd0), .idle(idle0));

  store_unit #(.XLEN(32), .AW(32), .DEPTH(DEPTH), .MISALIGN_SPLIT(1'b0)) u_nosplit32 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr1), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_data(req_data[31:0]), .err(er1), .dm_valid(dv1),
    .dm_ready(dm_ready), .dm_addr(da1), .dm_web(web1), .dm_wdata(wd1), .idle(idle1));

  store_unit #(.XLEN(64), .AW(32), .DEPTH(DEPTH), .MISALIGN_SPLIT(1'b1)) u_split64 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr2), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_data(req_data), .err(er2), .dm_valid(dv2),
    .dm_ready(dm_ready), .dm_addr(da2), .dm_web(web2), .dm_wdata(wd2), .idle(idle2));

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  // Model state per instance: stores held, expected beat ring, pending err.
  logic [31:0] q_addr [3][QN];
  logic [7:0]  q_web  [3][QN];
  logic [63:0] q_wd   [3][QN];
  bit          q_last [3][QN];
  int unsigned q_hd [3];
  int unsigned q_n  [3];
  int unsigned st_cnt [3];
  bit          err_exp [3];
  bit          sb_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int unsigned nb_of(input int unsigned k);
    return (k == 2) ? 8 : 4;
  endfunction

  // Place each stored byte at its absolute address, then group bytes per memory word.
  task automatic sb_push(input int unsigned k, input logic [1:0] lsz,
                         input logic [31:0] a, input logic [63:0] d);
    int unsigned nb, sz, first, ba, b, ln, slot;
    logic [7:0]  m [2];
    logic [63:0] w [2];
    nb = nb_of(k);
    sz = 1 << lsz;
    first = a / nb;
    m[0] = '0; m[1] = '0; w[0] = '0; w[1] = '0;
    for (int unsigned i = 0; i < sz; i++) begin
      ba = a + i;
      b  = ((ba / nb) == first) ? 0 : 1;
      ln = ba % nb;
      m[b][ln] = 1'b1;
      w[b][8*ln +: 8] = d[8*i +: 8];
    end
    for (int unsigned b2 = 0; b2 < 2; b2++) begin
      if (b2 == 0 || m[1] != 8'h00) begin
        slot = (q_hd[k] + q_n[k]) % QN;
        q_addr[k][slot] = 32'(first * nb + b2 * nb);
        q_web[k][slot]  = ~m[b2] & ((nb == 8) ? 8'hFF : 8'h0F);
        q_wd[k][slot]   = w[b2];
        q_last[k][slot] = (b2 == 1) || (m[1] == 8'h00);
        q_n[k]++;
      end
    end
  endtask

  task automatic sb_check(input int unsigned k, input logic dv, input logic rr, input logic idl,
                          input logic er, input logic [31:0] da, input logic [7:0] web,
                          input logic [63:0] wd);
    int unsigned h;
    chk($sformatf("i%0d_req_ready", k), rr, (st_cnt[k] < DEPTH) ? 64'd1 : 64'd0);
    chk($sformatf("i%0d_idle", k), idl, (st_cnt[k] == 0) ? 64'd1 : 64'd0);
    chk($sformatf("i%0d_err", k), er, err_exp[k] ? 64'd1 : 64'd0);
    if (st_cnt[k] == 0) chk($sformatf("i%0d_valid_empty", k), dv, 64'd0);
    if (dv === 1'b1) begin
      if (q_n[k] == 0) begin
        chk($sformatf("i%0d_valid_no_beat", k), dv, 64'd0);
      end else begin
        h = q_hd[k];
        chk($sformatf("i%0d_dm_addr", k), da, q_addr[k][h]);
        chk($sformatf("i%0d_dm_web", k), web, q_web[k][h]);
        chk($sformatf("i%0d_dm_wdata", k), wd, q_wd[k][h]);
      end
    end else begin
      chk($sformatf("i%0d_web_idle", k), web, (nb_of(k) == 8) ? 64'hFF : 64'h0F);
      chk($sformatf("i%0d_wdata_idle", k), wd, 64'd0);
    end
  endtask

  task automatic sb_adv(input int unsigned k, input logic dv);
    int unsigned held, nb, sz, off;
    bit bad;
    if (rst) begin
      q_hd[k] = 0; q_n[k] = 0; st_cnt[k] = 0; err_exp[k] = 1'b0;
      return;
    end
    held = st_cnt[k];
    if (dv === 1'b1 && dm_ready && q_n[k] > 0) begin
      if (q_last[k][q_hd[k]]) st_cnt[k]--;
      q_hd[k] = (q_hd[k] + 1) % QN;
      q_n[k]--;
    end
    err_exp[k] = 1'b0;
    if (req_valid && held < DEPTH) begin
      nb  = nb_of(k);
      sz  = 1 << req_funct3[1:0];
      off = req_addr % nb;
      bad = req_funct3[2] || (req_funct3[1:0] == 2'b11 && nb == 4) || (k == 1 && off + sz > nb);
      if (bad) begin
        err_exp[k] = 1'b1;
      end else begin
        sb_push(k, req_funct3[1:0], req_addr, req_data);
        st_cnt[k]++;
      end
    end
  endtask

  // One clock: compare on the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (sb_on) begin
      sb_check(0, dv0, rr0, idle0, er0, da0, {4'h0, web0}, {32'h0, wd0});
      sb_check(1, dv1, rr1, idle1, er1, da1, {4'h0, web1}, {32'h0, wd1});
      sb_check(2, dv2, rr2, idle2, er2, da2, web2, wd2);
    end
    sb_adv(0, dv0);
    sb_adv(1, dv1);
    sb_adv(2, dv2);
    if (rst) sb_on = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [63:0] d);
    req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_data = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    dm_ready  = 1'b1;
    for (int i = 0; i < 30 && !(idle0 === 1'b1 && idle1 === 1'b1 && idle2 === 1'b1); i++) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    chk("rst_valid", dv0, 0);  chk("rst_web", web0, 4'hF); chk("rst_wdata", wd0, 0);
    chk("rst_addr", da0, 0);   chk("rst_idle", idle0, 1);  chk("rst_ready", rr0, 1);
    chk("rst_err", er0, 0);
    rst = 1'b0;
    dm_ready = 1'b1;

    // SB latency and lane placement
    send(F3_SB, 32'h103, 64'hAABBCCDD);
    chk("sb_valid_n1", dv0, 0);
    step();
    chk("sb_valid_n2", dv0, 1); chk("sb_addr", da0, 32'h100);
    chk("sb_web", web0, 4'b0111); chk("sb_wdata", wd0, 32'hDD000000);
    step();
    chk("sb_idle_after", idle0, 1);

    // SH then SW back to back, no bubble
    send(F3_SH, 32'h102, 64'h00001234);
    send(F3_SW, 32'h200, 64'hCAFEF00D);
    chk("sh_valid", dv0, 1); chk("sh_addr", da0, 32'h100);
    chk("sh_web", web0, 4'b0011); chk("sh_wdata", wd0, 32'h12340000);
    step();
    chk("sw_valid", dv0, 1); chk("sw_addr", da0, 32'h200);
    chk("sw_web", web0, 4'b0000); chk("sw_wdata", wd0, 32'hCAFEF00D);
    step();
    chk("shsw_idle", idle0, 1);

    // Misaligned SW split into two beats
    send(F3_SW, 32'h103, 64'h11223344);
    chk("split_valid_n1", dv0, 0); chk("nosplit_err", er1, 1);
    step();
    chk("split_b0_addr", da0, 32'h100); chk("split_b0_web", web0, 4'b0111);
    chk("split_b0_wdata", wd0, 32'h44000000);
    step();
    chk("split_b1_addr", da0, 32'h104); chk("split_b1_web", web0, 4'b1000);
    chk("split_b1_wdata", wd0, 32'h00112233);
    step();
    chk("split_idle", idle0, 1);
    drain();

    // Back-pressure: fill the FIFO, hold outputs, then drain in order
    dm_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_ready", rr0, (i < 4) ? 64'd1 : 64'd0);
      send(F3_SB, 32'h300 + 32'(i), 64'hA0 + 64'(i));
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", dv0, 1); chk("stall_addr", da0, 32'h300);
      chk("stall_web", web0, 4'b1110); chk("stall_wdata", wd0, 32'h000000A0);
      step();
    end
    dm_ready = 1'b1;
    for (int i = 0; i < 20 && idle0 !== 1'b1; i++) step();
    chk("stall_drained_idle", idle0, 1);
    drain();

    // Rejected requests
    send(F3_SD, 32'h8, 64'h0123456789ABCDEF);
    chk("sd32_err", er0, 1); chk("sd64_err", er2, 0); chk("sd32_valid", dv0, 0);
    step();
    chk("sd32_err_once", er0, 0); chk("sd32_no_beat", dv0, 0);
    chk("sd64_valid", dv2, 1); chk("sd64_addr", da2, 32'h8);
    chk("sd64_web", web2, 8'h00); chk("sd64_wdata", wd2, 64'h0123456789ABCDEF);
    drain();
    send(F3_SH, 32'h103, 64'h5566);
    chk("nosplit_sh_err", er1, 1);
    step();
    chk("nosplit_sh_err_once", er1, 0); chk("nosplit_sh_no_beat", dv1, 0);
    drain();

    // Reset during BEAT1 with two entries queued
    dm_ready = 1'b0;
    send(F3_SW, 32'h103, 64'h11223344);
    send(F3_SB, 32'h40, 64'h77);
    chk("rmid_b0_addr", da0, 32'h100);
    dm_ready = 1'b1;
    step();
    chk("rmid_b1_addr", da0, 32'h104); chk("rmid_b1_web", web0, 4'b1000);
    dm_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid_valid", dv0, 0); chk("rmid_web", web0, 4'hF);
    chk("rmid_idle", idle0, 1); chk("rmid_ready", rr0, 1);
    dm_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rmid_no_beat", dv0, 0);
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 599) == 0);
      req_valid  = ($urandom_range(0, 1) == 1);
      req_funct3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      req_addr   = $urandom();
      req_data   = {$urandom(), $urandom()};
      dm_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;
    drain();
    chk("final_idle0", idle0, 1); chk("final_idle1", idle1, 1); chk("final_idle2", idle2, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
